// File: rtl/anode_scan_controller.sv
// Four-digit common-anode scan controller with frame-synchronous message scrolling.
// Optional AUTO_SCROLL_EN adds FRAMES_PER_STEP and a periodic automatic step.
//
// state   | meaning
// S_GUARD | start of a digit slot, all anodes off (anti-ghosting)
// S_ON    | anode of digit_sel driven low for the rest of the slot
module anode_scan_controller #(
    parameter int DIGIT_CYCLES = 16,
    parameter int GUARD_CYCLES = 2,
    parameter int MSG_LEN      = 16
`ifdef AUTO_SCROLL_EN
    ,
    parameter int FRAMES_PER_STEP = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_debounc,
    output logic [3:0] an,
    output logic [1:0] digit_sel,
    output logic [3:0] char_addr,
    output logic [3:0] scroll_pos
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [3:0]    POS_LAST  = 4'(MSG_LEN - 1);
    localparam logic [4:0]    LEN5      = 5'(MSG_LEN);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } state_t;

    localparam state_t S_SLOT_START = (GUARD_CYCLES == 0) ? S_ON : S_GUARD;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pending, prev_step;
    logic            wrap, boundary, step_edge, auto_step, apply_step;
    logic [1:0]      digit_nxt;
    logic [3:0]      scroll_nxt, char_nxt, an_nxt;
    logic [4:0]      char_sum;

`ifdef AUTO_SCROLL_EN
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES_PER_STEP - 1);

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    assign auto_step = boundary && (frame_cnt == FRM_LAST);
`else
    assign auto_step = 1'b0;
`endif

    // Slot timing, edge detection and the next values of every registered output.
    always_comb begin
        wrap       = (cnt == CNT_LAST);
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        boundary   = wrap && (digit_sel == 2'd0);
        step_edge  = step_debounc && !prev_step;
        apply_step = boundary && (pending || step_edge || auto_step);
        scroll_nxt = scroll_pos;
        if (apply_step) begin
            scroll_nxt = (scroll_pos == POS_LAST) ? 4'd0 : scroll_pos + 4'd1;
        end
        digit_nxt = wrap ? digit_sel - 2'd1 : digit_sel;
        char_sum  = {1'b0, scroll_nxt} + {3'b000, (2'd3 - digit_nxt)};
        char_nxt  = wrap ? 4'(char_sum % LEN5) : char_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_SLOT_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (wrap) begin
            state_nxt = S_SLOT_START;
        end else if (cnt_nxt == CNT_GUARD) begin
            state_nxt = S_ON;
        end
    end

    always_comb begin
        an_nxt = 4'b1111;
        if (state_nxt == S_ON) begin
            an_nxt = ~(4'b0001 << digit_nxt);
        end
    end

    // prev_step resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            digit_sel  <= 2'd3;
            char_addr  <= 4'd0;
            scroll_pos <= 4'd0;
            an         <= 4'b1111;
            pending    <= 1'b0;
            prev_step  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            digit_sel  <= digit_nxt;
            char_addr  <= char_nxt;
            scroll_pos <= scroll_nxt;
            an         <= an_nxt;
            prev_step  <= step_debounc;
            pending    <= boundary ? 1'b0 : (pending || step_edge);
        end
    end

endmodule
